// File: rtl/cp0_ctrl.sv
// CP0 for the 5-stage MIPS pipeline: SR/Cause/EPC/PRId, interrupt and exception arbitration.
// Optional Count/Compare timer (regs 9/11) is enabled by defining CP0_TIMER_EN.
module cp0_ctrl #(
  parameter logic [31:0] PRID_VALUE = 32'h2018_1123,
  parameter int unsigned HWINT_W    = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [4:0]         a1_i,
  input  logic [4:0]         a2_i,
  input  logic [31:0]        din_i,
  input  logic               we_i,
  input  logic [31:0]        pc_i,
  input  logic               bd_i,
  input  logic [4:0]         exc_code_i,
  input  logic [HWINT_W-1:0] hw_int_i,
  input  logic               exl_clr_i,
  output logic               int_req_o,
  output logic [31:0]        epc_o,
  output logic [31:0]        dout_o
);

  logic [5:0]  im_q, im_d, ip_q, ip_d, hw_lines;
  logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [29:0] epc_q, epc_d;
  logic        intp, excp, mtc0;
  logic [31:0] epc_src;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        ti_q, ti_d;
`endif

  always_comb begin
    hw_lines = 6'(hw_int_i);
`ifdef CP0_TIMER_EN
    hw_lines[5] = hw_lines[5] | ti_q;
`endif
  end

  assign intp      = ie_q & (|(hw_lines & im_q));
  assign excp      = (exc_code_i != 5'd0);
  assign int_req_o = ~exl_q & (intp | excp);
  // A write from a flushed instruction must not land.
  assign mtc0      = we_i & ~int_req_o;
  assign epc_src   = bd_i ? (pc_i - 32'd4) : pc_i;
  assign epc_o     = {epc_q, 2'b00};

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = hw_lines;
    if (int_req_o) begin
      exl_d      = 1'b1;
      bd_d       = bd_i;
      exc_code_d = intp ? 5'd0 : exc_code_i;
      epc_d      = epc_src[31:2];
    end else begin
      if (mtc0 && a2_i == 5'd12) begin
        im_d  = din_i[15:10];
        exl_d = din_i[1];
        ie_d  = din_i[0];
      end
      if (mtc0 && a2_i == 5'd14) epc_d = din_i[31:2];
      // eret wins over an SR write for EXL only.
      if (exl_clr_i) exl_d = 1'b0;
    end
  end

`ifdef CP0_TIMER_EN
  always_comb begin
    count_d   = (mtc0 && a2_i == 5'd9) ? din_i : count_q + 32'd1;
    compare_d = (mtc0 && a2_i == 5'd11) ? din_i : compare_q;
    if (mtc0 && a2_i == 5'd11)                            ti_d = 1'b0;
    else if (count_q == compare_q && compare_q != 32'd0) ti_d = 1'b1;
    else                                                  ti_d = ti_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      epc_q      <= 30'd0;
      ip_q       <= 6'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      ip_q       <= ip_d;
    end
  end

  always_comb begin
    dout_o = 32'd0;
    case (a1_i)
      5'd12:   dout_o = {16'd0, im_q, 8'd0, exl_q, ie_q};
      5'd13:   dout_o = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
      5'd14:   dout_o = {epc_q, 2'b00};
      5'd15:   dout_o = PRID_VALUE;
`ifdef CP0_TIMER_EN
      5'd9:    dout_o = count_q;
      5'd11:   dout_o = compare_q;
`endif
      default: dout_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: driver pushes reference-model predictions, monitor compares.
module tb_cp0_ctrl;

  localparam logic [31:0] PRID = 32'h2018_1123;

  logic        clk, rst, we, bd, exl_clr, int_req;
  logic [4:0]  a1, a2, exc_code;
  logic [31:0] din, pc, epc, dout;
  logic [5:0]  hw_int;

  cp0_ctrl #(.PRID_VALUE(PRID), .HWINT_W(6)) dut (
    .clk_i(clk), .rst_i(rst), .a1_i(a1), .a2_i(a2), .din_i(din), .we_i(we),
    .pc_i(pc), .bd_i(bd), .exc_code_i(exc_code), .hw_int_i(hw_int),
    .exl_clr_i(exl_clr), .int_req_o(int_req), .epc_o(epc), .dout_o(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] epc;
    logic [31:0] dout;
    logic [4:0]  a1;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: architectural register words.
  logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
  logic        m_ti;

  function automatic logic [31:0] model_read(input logic [4:0] r);
    case (r)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
`ifdef CP0_TIMER_EN
      5'd9:    return m_count;
      5'd11:   return m_compare;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic step(input logic r, input logic w, input logic [4:0] ra, input logic [4:0] wa,
                      input logic [31:0] d, input logic [31:0] p, input logic b,
                      input logic [4:0] c, input logic [5:0] h, input logic x);
    exp_t        e;
    logic [5:0]  lines;
    logic        ip, req, wr_ok;
    logic [31:0] code_w, lines_w;
    @(negedge clk);
    rst = r; we = w; a1 = ra; a2 = wa; din = d; pc = p; bd = b;
    exc_code = c; hw_int = h; exl_clr = x;
    if (r) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_ti = 1'b0;
    end
    lines = h;
`ifdef CP0_TIMER_EN
    lines[5] = lines[5] | m_ti;
`endif
    ip  = m_sr[0] && ((lines & m_sr[15:10]) != 6'd0);
    req = !m_sr[1] && (ip || c != 5'd0);
    e.req = req; e.epc = m_epc; e.dout = model_read(ra); e.a1 = ra;
    sb_q.push_back(e);
    if (!r) begin
      wr_ok = w && !req;
`ifdef CP0_TIMER_EN
      if (wr_ok && wa == 5'd11) m_ti = 1'b0;
      else if (m_count == m_compare && m_compare != 0) m_ti = 1'b1;
      m_count = (wr_ok && wa == 5'd9) ? d : m_count + 1;
      if (wr_ok && wa == 5'd11) m_compare = d;
`endif
      if (req) begin
        code_w  = ip ? 32'd0 : {27'd0, c};
        m_sr    = m_sr | 32'h2;
        m_cause = ({31'd0, b} << 31) | (code_w << 2);
        m_epc   = (b ? p - 32'd4 : p) & ~32'h3;
      end else begin
        if (wr_ok && wa == 5'd12) m_sr = d & 32'h0000_FC03;
        if (wr_ok && wa == 5'd14) m_epc = d & ~32'h3;
        if (x) m_sr = m_sr & ~32'h2;
      end
      lines_w = {26'd0, lines};
      m_cause = (m_cause & ~32'h0000_FC00) | (lines_w << 10);
    end
  endtask

  task automatic rand_step();
    logic [4:0]  ra, wa;
    logic [31:0] d;
    ra = pick_reg();
    wa = pick_reg();
    d  = $urandom;
    if (wa == 5'd12 && $urandom_range(0, 1) == 0) d[1] = 1'b0;
    step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), ra, wa, d, $urandom,
         1'($urandom), ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0,
         ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0, ($urandom_range(0, 5) == 0));
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 7))
      0:       return 5'd9;
      1:       return 5'd11;
      2:       return 5'd12;
      3:       return 5'd13;
      4:       return 5'd14;
      5:       return 5'd15;
      6:       return 5'd7;
      default: return 5'($urandom);
    endcase
  endfunction

  // Monitor: outputs are combinational, so compare mid-cycle before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total += 3;
        if (int_req !== e.req) begin
          bad++;
          $display("FAIL int_req t=%0t got=%b want=%b", $time, int_req, e.req);
        end
        if (epc !== e.epc) begin
          bad++;
          $display("FAIL epc t=%0t got=%h want=%h", $time, epc, e.epc);
        end
        if (dout !== e.dout) begin
          bad++;
          $display("FAIL dout a1=%0d t=%0t got=%h want=%h", e.a1, $time, dout, e.dout);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; we = 0; a1 = 0; a2 = 0; din = 0; pc = 0; bd = 0;
    exc_code = 0; hw_int = 0; exl_clr = 0;
    m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_ti = 1'b0;

    step(1, 0, 12, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 13, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 12, 12, 32'h401, 0, 0, 0, 0, 0);
    step(0, 0, 12, 0, 0, 32'h3010, 0, 0, 6'd1, 0);
    step(0, 0, 14, 0, 0, 32'h3014, 0, 0, 6'd1, 0);
    step(0, 0, 13, 0, 0, 0, 0, 0, 6'd1, 0);
    step(0, 0, 12, 0, 0, 0, 0, 0, 6'd1, 1);
    step(0, 0, 14, 0, 0, 32'h3100, 0, 0, 6'd1, 0);
    step(0, 0, 12, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 12, 12, 32'h0, 0, 0, 0, 0, 0);
    step(0, 0, 12, 0, 0, 32'h3024, 1, 5'd10, 0, 0);
    step(0, 0, 14, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 13, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 12, 12, 32'h401, 0, 0, 0, 0, 1);
    step(0, 1, 14, 14, 32'h5555, 32'h4000, 0, 0, 6'd1, 0);
    step(0, 0, 14, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 12, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 14, 14, 32'h3007, 0, 0, 0, 0, 0);
    step(0, 0, 14, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 15, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 13, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    step(0, 1, 15, 15, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    step(0, 0, 13, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 12, 0, 0, 32'h5008, 0, 5'd4, 0, 0);
    step(0, 0, 14, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 14, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 12, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 13, 0, 0, 0, 0, 0, 0, 0);

    repeat (600) rand_step();

`ifdef CP0_TIMER_EN
    step(1, 0, 9, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 11, 11, 32'd5, 0, 0, 0, 0, 0);
    step(0, 1, 9, 12, 32'h8001, 0, 0, 0, 0, 0);
    repeat (8) step(0, 0, 13, 0, 0, 32'h6000, 0, 0, 0, 0);
    step(0, 1, 11, 11, 32'd0, 0, 0, 0, 0, 0);
    step(0, 0, 13, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 9, 0, 0, 0, 0, 0, 0, 0);
`endif

    step(0, 0, 12, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #6;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
